packet_output_arbiter: RTL
==========================

Name: packet_output_arbiter

Overview:
- Per-output-port switch allocator for the mesh Router.
- Shares one output channel among INPUTS input-port FIFOs using round-robin arbitration.
- Holds the grant for a whole wormhole packet, from head flit to tail flit, so flits of different packets never interleave on the output.
- Muxes the granted input's data/valid onto the output link and returns ready to the granted input only.

Parameters:
- INPUTS, 3, number of requesting input ports (≥2).
- DATA_WIDTH, 32, flit width in bits.
- TYPE_WIDTH, 2, flit-type field width; the field occupies data[DATA_WIDTH-1 -: TYPE_WIDTH].
- REQUEST_WIDTH, $clog2(INPUTS), width of the select index.
- FlitPerPacket, 6, maximum flits per packet; the lock is force-released after this many transfers.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- req_bus, input, INPUTS, bit i: input i has a head flit routed to this output.
- data_in_bus, input, INPUTS*DATA_WIDTH, flit from each input; input i is at slice [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in_bus, input, INPUTS, per-input flit valid.
- ready_in_bus, output, INPUTS, per-input ready back to the FIFOs.
- data_out, output, DATA_WIDTH, flit to the downstream link.
- valid_out, output, 1, downstream valid.
- ready_out, input, 1, downstream ready.
- grant, output, INPUTS, one-hot registered grant; all-zero when idle.
- sel, output, REQUEST_WIDTH, index of the granted input.
- locked, output, 1, arbiter is holding a packet.
- protocol_err, output, 1, one-cycle pulse on a flit-type violation.

Behaviour:
- Reset, async, rst=1. State goes to IDLE; grant=0, sel=0, locked=0, protocol_err=0, flit count=0, rr pointer=0. Combinationally valid_out=0, ready_in_bus=0, data_out=0.
- Flit types: 01 head, 10 body, 11 tail, 00 reserved (illegal).
- IDLE:
  - If req_bus≠0, pick the first set bit searching from pointer upward with wrap-around.
  - Register grant/sel and enter LOCKED. The grant appears one cycle after req is sampled.
  - If req_bus=0, stay in IDLE.
- LOCKED:
  - valid_out = valid_in_bus[sel].
  - data_out = granted data slice.
  - ready_in_bus = grant when ready_out=1, else 0.
  - transfer = valid_out & ready_out.
  - Each transfer increments the flit count (width $clog2(FlitPerPacket+1)).
- Release:
  - Occurs on a transfer whose type is tail, or on the transfer that makes count=FlitPerPacket.
  - Next cycle: state=IDLE, grant=0, locked=0, count=0, pointer=(sel+1) mod INPUTS.
  - The next grant is issued no earlier than 2 cycles after the releasing transfer (one IDLE bubble, fixed).
- Protocol errors: protocol_err pulses for one cycle (registered) when any of these occurs:
  - the first transfer in LOCKED is not head;
  - a later transfer is head;
  - any transfer has type 00;
  - release is forced by the count limit without a tail.
- The error does not alter sequencing; a head received mid-packet is forwarded as data.
- Back-pressure: ready_out=0 holds the state and count; the grant is never dropped mid-packet.
- valid_in deasserting mid-packet (FIFO underrun) keeps the lock.
- req_bus changes while LOCKED are ignored.
- Single-flit packets of type tail are illegal as a first flit (first must be head). The first transfer is checked as head before the tail check.
- A reset asserted mid-packet aborts immediately. No flit is lost on the output side, but the packet is truncated; upstream recovery is outside this block.
- Non-granted inputs always see ready=0.

Test Plan:
- Reset then req_bus=3'b110 → grant=3'b010 at cycle+1, sel=1, locked=1. Stream head/body/body/tail with ready_out=1 → 4 transfers, data_out matches input 1, grant=0 the cycle after the tail, pointer=2.
- Contention: req_bus=3'b111 held, each input sends 3-flit packets → grant order 001, 010, 100, 001, with one idle cycle between packets.
- Back-pressure: ready_out toggles 1,0,0,1 during a 6-flit packet → ready_in_bus[sel] mirrors ready_out, count stalls at zeros, release only after the 6th transfer.
- Force release: 6 transfers head+5 body with no tail → release after the 6th, protocol_err=1 for exactly one cycle.
- Bad first flit: grant to input 0, first flit type 10 → protocol_err pulse; the packet still forwards and releases on tail.
- Async reset mid-packet after 2 of 4 flits → grant, locked, valid_out, ready_in_bus go 0 without a clock edge; after reset, req_bus=3'b100 → grant=3'b100 (pointer restarted at 0).

Source files
------------

// File: rtl/packet_output_arbiter.sv
// Output-port switch allocator: round-robin grant among input FIFOs, held for a
// whole wormhole packet (head..tail, or a flit-count limit), with the granted
// input's flit muxed onto the output link.
module packet_output_arbiter #(
    parameter int INPUTS        = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int REQUEST_WIDTH = $clog2(INPUTS),
    parameter int FlitPerPacket = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS-1:0]            req_bus,
    input  logic [INPUTS*DATA_WIDTH-1:0] data_in_bus,
    input  logic [INPUTS-1:0]            valid_in_bus,
    output logic [INPUTS-1:0]            ready_in_bus,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [INPUTS-1:0]            grant,
    output logic [REQUEST_WIDTH-1:0]     sel,
    output logic                         locked,
    output logic                         protocol_err
);
    localparam int CNT_W = $clog2(FlitPerPacket + 1);

    localparam logic [TYPE_WIDTH-1:0] T_RSVD = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(3);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                     state_q, state_d;
    logic [INPUTS-1:0]          grant_q, grant_d;
    logic [REQUEST_WIDTH-1:0]   sel_q, sel_d;
    logic [REQUEST_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       locked_q, locked_d;
    logic                       err_q, err_d;

    logic [DATA_WIDTH-1:0]      gnt_data;
    logic                       gnt_valid;
    logic                       pick_found;
    logic [REQUEST_WIDTH-1:0]   pick_idx;
    logic [TYPE_WIDTH-1:0]      ftype;
    logic                       xfer;
    logic                       first_flit;
    logic                       at_limit;
    logic                       is_tail;

    // Select the granted input's flit and valid.
    always_comb begin
        gnt_data  = '0;
        gnt_valid = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (sel_q == REQUEST_WIDTH'(i)) begin
                gnt_data  = data_in_bus[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_valid = valid_in_bus[i];
            end
        end
    end

    // Round-robin search: first requester at or above the pointer, wrapping.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < INPUTS; k++) begin
            idx = (int'(ptr_q) + k) % INPUTS;
            if (!pick_found && req_bus[idx]) begin
                pick_found = 1'b1;
                pick_idx   = REQUEST_WIDTH'(idx);
            end
        end
    end

    // Link outputs are only driven while a packet is held.
    always_comb begin
        valid_out    = locked_q & gnt_valid;
        data_out     = locked_q ? gnt_data : '0;
        ready_in_bus = (locked_q & ready_out) ? grant_q : '0;
    end

    // Transfer decode: flit type, position within packet, release conditions.
    always_comb begin
        ftype      = gnt_data[DATA_WIDTH-1 -: TYPE_WIDTH];
        xfer       = valid_out & ready_out;
        first_flit = (cnt_q == '0);
        at_limit   = (cnt_q == CNT_W'(FlitPerPacket - 1));
        is_tail    = (ftype == T_TAIL);
    end

    // Next-state: grant on request in IDLE, count and release in LOCKED.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = LOCKED;
                    grant_d  = INPUTS'(1) << pick_idx;
                    sel_d    = pick_idx;
                    cnt_d    = '0;
                    locked_d = 1'b1;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Errors are flagged only; the flit is still forwarded.
                    err_d = (first_flit && ftype != T_HEAD) ||
                            (!first_flit && ftype == T_HEAD) ||
                            (ftype == T_RSVD) ||
                            (at_limit && !is_tail);
                    if (is_tail || at_limit) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        cnt_d    = '0;
                        locked_d = 1'b0;
                        ptr_d    = (sel_q == REQUEST_WIDTH'(INPUTS - 1)) ? '0 : sel_q + REQUEST_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                locked_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // State registers; reset aborts any held packet immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign grant        = grant_q;
    assign sel          = sel_q;
    assign locked       = locked_q;
    assign protocol_err = err_q;

endmodule
